// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state encoding, default parameters and helpers for the bus cycle arbiter.
package bus_arb_pkg;

    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        T1   = 6'b000010,
        T2   = 6'b000100,
        TW   = 6'b001000,
        T3   = 6'b010000,
        T4   = 6'b100000
    } state_t;

    localparam int NREQ_DEF    = 4;
    localparam int AW_DEF      = 16;
    localparam int DW_DEF      = 8;
    localparam int MAXWAIT_DEF = 15;

    function automatic int clog2(input int n);
        for (int r = 1; r < 32; r++)
            if ((1 << r) >= n) return r;
        return 32;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   idx,
    output logic            any_req
);

    logic [IW-1:0] j;

    assign any_req = |req;

    // Scan from farthest to nearest so the candidate closest to ptr wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        j    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % NREQ);
            if (req[j]) begin
                idx  = j;
                pick = NREQ'(1) << j;
            end
        end
    end

endmodule

// File: rtl/bus_cycle_arbiter.sv
// bus_cycle_arbiter: round-robin sharing of one multiplexed bus, sequencing T1/T2/TW/T3/T4 cycles.
// Define BUS_WAIT_TIMEOUT_EN to abort wait states after MAXWAIT cycles with an err pulse.
module bus_cycle_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int MAXWAIT = MAXWAIT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rdata,
    output logic           err,
    output logic           ale,
    output logic           cs_n,
    output logic           rd_n,
    output logic           wr_n,
    output logic [AW-1:0]  bus_addr,
    output logic [DW-1:0]  bus_wdata,
    output logic           bus_wdata_oe,
    input  logic [DW-1:0]  bus_rdata,
    input  logic           ready
);

    localparam int IW = clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || MAXWAIT < 1) begin : g_bad_cfg
        $error("bus_cycle_arbiter: unsupported NREQ or MAXWAIT");
    end

    state_t          state, nxt;
    logic [IW-1:0]   ptr, idx, pick_idx;
    logic [NREQ-1:0] pick, gnt_l;
    logic            any_req, we_l, strobe, tmo;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req     (req),
        .ptr     (ptr),
        .pick    (pick),
        .idx     (pick_idx),
        .any_req (any_req)
    );

`ifdef BUS_WAIT_TIMEOUT_EN
    localparam int CW = (clog2(MAXWAIT + 1) < 4) ? 4 : clog2(MAXWAIT + 1);
    logic [CW-1:0] cnt;
    logic          tmo_hit;

    assign tmo = cnt == CW'(MAXWAIT - 1);
    assign err = (state == T4) && tmo_hit;

    // cnt sits at zero outside TW, so it is clear on every TW entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            tmo_hit <= 1'b0;
        end else begin
            cnt     <= (state == TW) ? cnt + 1'b1 : '0;
            tmo_hit <= (state == TW) && !ready && tmo;
        end
    end
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = any_req ? T1 : IDLE;
            T1:      nxt = T2;
            T2:      nxt = ready ? T3 : TW;
            TW:      nxt = ready ? T3 : (tmo ? T4 : TW);
            T3:      nxt = T4;
            T4:      nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            idx       <= '0;
            gnt_l     <= '0;
            we_l      <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata     <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                idx       <= pick_idx;
                gnt_l     <= pick;
                we_l      <= we[pick_idx];
                bus_addr  <= addr[pick_idx*AW +: AW];
                bus_wdata <= wdata[pick_idx*DW +: DW];
            end
            if (state == T3 && !we_l) rdata <= bus_rdata;
            if (state == T4) ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
    end

    assign strobe       = (state == T2) || (state == TW) || (state == T3);
    assign gnt          = (state == IDLE) ? '0 : gnt_l;
    assign done         = (state == T4) ? gnt_l : '0;
    assign ale          = state == T1;
    assign cs_n         = !(ale || strobe);
    assign rd_n         = !(strobe && !we_l);
    assign wr_n         = !(strobe && we_l);
    assign bus_wdata_oe = strobe && we_l;

endmodule
